// File: rtl/range_sequencer.sv
// Launch controller and result browser for the range engine: starts a run from
// the switch value, then lets the user step through the engine's result RAM.
module range_sequencer #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int REPEAT_CYCLES = 2**23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  sw,
  input  logic        start_req,
  input  logic        inc_req,
  input  logic        dec_req,
  input  logic        home_req,
  output logic        range_go,
  output logic [31:0] range_start,
  input  logic        range_done,
  input  logic [15:0] range_count,
  output logic [11:0] disp_n,
  output logic [15:0] disp_count,
  output logic        busy,
  output logic        valid
);

  localparam int REP_BITS = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_BITS-1:0]      REP_LAST = REP_BITS'(REPEAT_CYCLES - 1);
  localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX  = RAM_ADDR_BITS'(RAM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, SHOW} state_t;

  state_t                   state_reg;
  logic                     start_prev_reg, inc_prev_reg, dec_prev_reg;
  logic [9:0]               base_reg;
  logic [RAM_ADDR_BITS-1:0] offset_reg, offset_next;
  logic [REP_BITS-1:0]      rep_reg, rep_next;
  logic [1:0]               settle_reg;
  logic                     range_go_reg, valid_reg;
  logic [31:0]              range_start_reg;
  logic [15:0]              disp_count_reg;

  logic start_rise, inc_only, dec_only, step;

  assign start_rise = start_req & ~start_prev_reg;
  assign inc_only   = inc_req & ~dec_req;
  assign dec_only   = dec_req & ~inc_req;

  // A lone request steps on its rising edge, then every REPEAT_CYCLES while held.
  always_comb begin
    rep_next    = '0;
    step        = 1'b0;
    offset_next = offset_reg;
    if (inc_only || dec_only) begin
      if ((inc_only && !inc_prev_reg) || (dec_only && !dec_prev_reg))
        step = 1'b1;
      else if (rep_reg == REP_LAST)
        step = 1'b1;
      else
        rep_next = rep_reg + 1'b1;
    end
    if (home_req)
      offset_next = '0;
    else if (step && inc_only && offset_reg != OFF_MAX)
      offset_next = offset_reg + 1'b1;
    else if (step && dec_only && offset_reg != '0)
      offset_next = offset_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      start_prev_reg  <= 1'b0;
      inc_prev_reg    <= 1'b0;
      dec_prev_reg    <= 1'b0;
      base_reg        <= '0;
      offset_reg      <= '0;
      rep_reg         <= '0;
      settle_reg      <= '0;
      range_go_reg    <= 1'b0;
      range_start_reg <= '0;
      disp_count_reg  <= '0;
      valid_reg       <= 1'b0;
    end else begin
      start_prev_reg <= start_req;
      inc_prev_reg   <= inc_req;
      dec_prev_reg   <= dec_req;
      range_go_reg   <= 1'b0;
      rep_reg        <= '0;
      case (state_reg)
        IDLE, SHOW: begin
          if (start_rise) begin
            state_reg       <= LAUNCH;
            base_reg        <= sw;
            range_start_reg <= {22'b0, sw};
            range_go_reg    <= 1'b1;
            valid_reg       <= 1'b0;
            settle_reg      <= '0;
          end else if (state_reg == SHOW) begin
            rep_reg <= rep_next;
            if (offset_next != offset_reg) begin
              offset_reg      <= offset_next;
              range_start_reg <= 32'(offset_next);
              valid_reg       <= 1'b0;
              settle_reg      <= 2'd2;
            end else if (settle_reg != '0) begin
              settle_reg <= settle_reg - 1'b1;
              if (settle_reg == 2'd1) begin
                disp_count_reg <= range_count;
                valid_reg      <= 1'b1;
              end
            end
          end
        end
        LAUNCH: state_reg <= RUN;
        RUN: begin
          if (range_done) begin
            state_reg       <= SHOW;
            offset_reg      <= '0;
            range_start_reg <= '0;
            valid_reg       <= 1'b0;
            settle_reg      <= 2'd2;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_reg)
      IDLE:    disp_n = {2'b0, sw};
      SHOW:    disp_n = 12'({2'b0, base_reg}) + 12'(offset_reg);
      default: disp_n = {2'b0, base_reg};
    endcase
  end

  assign range_go    = range_go_reg;
  assign range_start = range_start_reg;
  assign disp_count  = disp_count_reg;
  assign valid       = valid_reg;
  assign busy        = (state_reg == LAUNCH) || (state_reg == RUN);

endmodule

// File: tb/tb_range_sequencer.sv
// Randomized scoreboard bench for range_sequencer: stimulus pushes expected
// launch/result events, a negedge monitor pops and compares them.
module tb_range_sequencer;
  localparam int REP = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  sw = '0;
  logic        start_req = 1'b0, inc_req = 1'b0, dec_req = 1'b0, home_req = 1'b0;
  logic        range_done = 1'b0;
  logic [15:0] range_count;
  logic        range_go, busy, valid;
  logic [31:0] range_start;
  logic [11:0] disp_n;
  logic [15:0] disp_count;

  always #5 clk = ~clk;

  range_sequencer #(.RAM_WORDS(256), .RAM_ADDR_BITS(8), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .start_req(start_req),
    .inc_req(inc_req), .dec_req(dec_req), .home_req(home_req),
    .range_go(range_go), .range_start(range_start), .range_done(range_done),
    .range_count(range_count), .disp_n(disp_n), .disp_count(disp_count),
    .busy(busy), .valid(valid)
  );

  // Engine result RAM with registered read at range_start.
  logic [15:0] mem [256];
  always @(posedge clk) range_count <= mem[range_start[7:0]];

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {bit is_go; int n; int cnt; int rs;} exp_t;
  exp_t sbq[$];

  int m_base = 0, m_off = 0;

  task automatic push_go(int s);
    exp_t e;
    e.is_go = 1'b1; e.n = 0; e.cnt = 0; e.rs = s;
    sbq.push_back(e);
  endtask

  task automatic push_show();
    exp_t e;
    e.is_go = 1'b0; e.n = (m_base + m_off) % 4096; e.cnt = int'(mem[m_off]); e.rs = m_off;
    sbq.push_back(e);
  endtask

  // Monitor: one transaction line per popped event.
  int   go_total = 0;
  logic go_q = 1'b0, valid_q = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (range_go) begin
      go_total++;
      if (go_q) chk("go_width_cycles", 2, 1);
      if (sbq.size() == 0) chk("unexpected_go", 1, 0);
      else begin
        me = sbq.pop_front();
        chk("go_kind", me.is_go, 1);
        chk("go_range_start", range_start, me.rs);
        $display("go   start=%0d", range_start);
      end
    end
    if (valid && !valid_q) begin
      if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        me = sbq.pop_front();
        chk("show_kind", me.is_go, 0);
        chk("show_disp_n", disp_n, me.n);
        chk("show_disp_count", disp_count, me.cnt);
        chk("show_range_start", range_start, me.rs);
        $display("show n=%0d count=%0d addr=%0d", disp_n, disp_count, range_start);
      end
    end
    go_q    <= range_go;
    valid_q <= valid;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(logic [9:0] s);
    sw = s; start_req = 1'b1;
    push_go(int'(s));
    m_base = int'(s);
    tick(1);
    start_req = 1'b0;
    tick(1);
    chk("busy_in_run", busy, 1);
  endtask

  task automatic finish_run(int wait_cyc);
    tick(wait_cyc);
    chk("busy_before_done", busy, 1);
    m_off = 0;
    push_show();
    range_done = 1'b1;
    tick(1);
    range_done = 1'b0;
    tick(3);
    chk("busy_after_done", busy, 0);
  endtask

  // Hold a request combination for `cycles` edges; model steps at 0, REP, 2*REP, ...
  task automatic hold(bit inc, bit dec, bit home, int cycles, int gap);
    int nxt;
    for (int k = 0; k < cycles; k++) begin
      nxt = m_off;
      if (home) nxt = 0;
      else if ((inc ^ dec) && (k % REP == 0))
        nxt = inc ? ((m_off < 255) ? m_off + 1 : 255) : ((m_off > 0) ? m_off - 1 : 0);
      if (nxt != m_off) begin
        m_off = nxt;
        push_show();
      end
    end
    inc_req = inc; dec_req = dec; home_req = home;
    tick(cycles);
    inc_req = 1'b0; dec_req = 1'b0; home_req = 1'b0;
    tick(gap);
  endtask

  initial begin
    int gb;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    sw = 10'($urandom);
    tick(2);
    chk("rst_range_go", range_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_range_start", range_start, 0);
    chk("rst_disp_count", disp_count, 0);
    chk("rst_disp_n", disp_n, {2'b0, sw});
    reset_n = 1'b1;
    tick(1);

    for (int i = 0; i < 3; i++) begin
      sw = 10'($urandom);
      tick(1);
      chk("idle_disp_n", disp_n, {2'b0, sw});
      chk("idle_valid", valid, 0);
    end

    launch(10'd27);
    finish_run(5);
    chk("first_disp_n", disp_n, 27);
    chk("first_valid", valid, 1);
    chk("first_disp_count", disp_count, mem[0]);

    m_off = 1; push_show();
    inc_req = 1'b1;
    tick(1);
    chk("step_valid_low1", valid, 0);
    chk("step_range_start", range_start, 1);
    inc_req = 1'b0;
    tick(1);
    chk("step_valid_low2", valid, 0);
    tick(1);
    chk("step_valid_high", valid, 1);
    chk("step_disp_n", disp_n, 28);
    tick(1);
    for (int i = 0; i < 300; i++) hold(1'b1, 1'b0, 1'b0, 1, 3);
    chk("sat_range_start", range_start, 255);
    chk("sat_disp_n", disp_n, 282);

    launch(10'($urandom));
    finish_run(1 + $urandom_range(0, 6));
    hold(1'b1, 1'b0, 1'b0, 30, 4);
    chk("repeat_offset", range_start, 4);
    hold(1'b1, 1'b1, 1'b0, 30, 4);
    chk("both_offset", range_start, 4);
    chk("both_valid", valid, 1);
    hold(1'b0, 1'b1, 1'b0, 20, 4);
    chk("dec_repeat_offset", range_start, 1);

    hold(1'b1, 1'b0, 1'b0, 98 * REP + 1, 4);
    chk("reach_100", range_start, 100);
    hold(1'b1, 1'b0, 1'b1, 1, 4);
    chk("home_offset", range_start, 0);
    chk("home_disp_n", disp_n, m_base);
    hold(1'b0, 1'b1, 1'b0, 1, 4);
    chk("dec_at0_offset", range_start, 0);
    chk("dec_at0_valid", valid, 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: hold(1'b1, 1'b0, 1'b0, $urandom_range(1, 40), 4);
        1: hold(1'b0, 1'b1, 1'b0, $urandom_range(1, 40), 4);
        2: hold(1'b1, 1'b1, 1'b0, $urandom_range(1, 20), 4);
        3: hold(1'b0, 1'b0, 1'b1, $urandom_range(1, 5), 4);
        default: hold(1'b0, 1'b1, 1'b1, $urandom_range(1, 5), 4);
      endcase
      chk("rand_offset", range_start, m_off);
    end

    range_done = 1'b1;
    tick(1);
    range_done = 1'b0;
    tick(3);
    chk("done_in_show_valid", valid, 1);
    chk("done_in_show_busy", busy, 0);

    gb = go_total;
    sw = 10'($urandom);
    start_req = 1'b1;
    push_go(int'(sw));
    m_base = int'(sw);
    tick(4);
    inc_req = 1'b1;
    tick(1);
    inc_req = 1'b0;
    tick(5);
    m_off = 0; push_show();
    range_done = 1'b1;
    tick(1);
    range_done = 1'b0;
    tick(89);
    start_req = 1'b0;
    tick(4);
    chk("held_start_go_count", go_total - gb, 1);
    chk("held_start_offset", range_start, 0);

    launch(10'($urandom));
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_range_go", range_go, 0);
    chk("arst_range_start", range_start, 0);
    chk("arst_valid", valid, 0);
    chk("arst_disp_count", disp_count, 0);
    chk("arst_disp_n", disp_n, {2'b0, sw});
    tick(2);
    reset_n = 1'b1;
    tick(1);
    range_done = 1'b1;
    tick(1);
    range_done = 1'b0;
    tick(3);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", valid, 0);
    sw = 10'($urandom);
    tick(1);
    chk("post_rst_disp_n", disp_n, {2'b0, sw});

    launch(10'($urandom));
    finish_run(3);
    hold(1'b1, 1'b0, 1'b0, 3, 4);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick(1);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/range_sequencer.md
RANGE_SEQUENCER -- requirements
Module: range_sequencer

Interface
REQ-001 Parameter RAM_WORDS, default 256: number of result words held by the range engine.
REQ-002 Parameter RAM_ADDR_BITS, default 8: width of the result offset; 2**RAM_ADDR_BITS = RAM_WORDS.
REQ-003 Parameter REPEAT_CYCLES, default 2**23: auto-repeat period for held step buttons, in clk cycles.
REQ-004 Port clk, in, 1: single clock for all state.
REQ-005 Port reset_n, in, 1: asynchronous, active-low reset.
REQ-006 Port sw, in, 10: base value n selected on the switches.
REQ-007 Port start_req, in, 1: launch request, active-high level, already synchronized.
REQ-008 Port inc_req / dec_req / home_req, in, 1 each: browse requests, active-high levels, already synchronized.
REQ-009 Port range_go, out, 1: one-cycle launch pulse to the range engine.
REQ-010 Port range_start, out, 32: start value during launch, result address during browse.
REQ-011 Port range_done, in, 1: engine completion pulse.
REQ-012 Port range_count, in, 16: iteration count read back from the engine at address range_start.
REQ-013 Port disp_n, out, 12: n value to display.
REQ-014 Port disp_count, out, 16: iteration count to display.
REQ-015 Port busy, out, 1: high in LAUNCH and RUN.
REQ-016 Port valid, out, 1: disp_count matches disp_n.

Function
REQ-017 FSM states: IDLE, LAUNCH, RUN, SHOW.
REQ-018 start_req is rising-edge detected; a held level launches once only.
REQ-019 IDLE: disp_n = {2'b0, sw} every cycle; disp_count held; valid = 0; range_go = 0.
REQ-020 IDLE or SHOW, start_req rising edge: latch base <= sw, range_start <= sw zero-extended, go to LAUNCH.
REQ-021 LAUNCH lasts exactly one cycle with range_go = 1, then RUN; range_go is never high outside LAUNCH.
REQ-022 RUN: hold range_start; ignore start_req and all browse requests; on range_done go to SHOW with offset = 0.
REQ-023 range_done outside RUN is ignored.
REQ-024 SHOW: range_start = offset zero-extended to 32 bits; disp_n = (base + offset) mod 4096.
REQ-025 Any offset change, including entry to SHOW, clears valid and starts a 2-cycle settle counter.
REQ-026 When the settle counter expires: disp_count <= range_count, valid <= 1; both hold until the next offset change.
REQ-027 Step on the inc_req (dec_req) rising edge, then once every REPEAT_CYCLES cycles while that request stays high.
REQ-028 inc_req and dec_req both high: no step, and the repeat timer is cleared.
REQ-029 Offset saturates: inc at RAM_WORDS-1 and dec at 0 are no-ops; these no-ops do not clear valid.
REQ-030 home_req high: offset <= 0, overriding inc/dec in the same cycle; valid clears only if offset was nonzero.
REQ-031 start_req rising edge in SHOW relaunches with the current sw; browse requests in that cycle are ignored.
REQ-032 busy = (state == LAUNCH || state == RUN).

Reset
REQ-033 reset_n low, asynchronously: state IDLE, range_go 0, range_start 0, base 0, offset 0, disp_count 0, valid 0, repeat timer 0, settle counter 0, edge registers 0.
REQ-034 Reset mid-RUN abandons the run; a range_done arriving after reset release is ignored.

Verification
REQ-035 sw=27, start_req pulse -> range_go high exactly 1 cycle with range_start=27; busy high until range_done; then disp_n=27, valid high 2 cycles later with disp_count=range_count.
REQ-036 SHOW with base=27, one inc_req pulse -> range_start=1, disp_n=28, valid low for 2 cycles; 300 further inc pulses -> offset stops at 255, disp_n=282.
REQ-037 inc_req held with REPEAT_CYCLES=8 for 30 cycles -> offset steps at cycles 0, 8, 16, 24 (4 steps); inc_req and dec_req held together -> offset unchanged.
REQ-038 offset=100, home_req asserted together with inc_req -> offset=0, disp_n=base; dec_req at offset 0 -> no change, valid stays high.
REQ-039 start_req held high for 100 cycles across launch and completion -> exactly one range_go pulse.
REQ-040 reset_n low during RUN -> immediate IDLE, all outputs 0, disp_n follows sw; a range_done pulse after release -> no state change.
